// File: rtl/logger_pkg.sv
// Shared definitions for the ping-pong sample logger: bank-state encoding
// and default widths.
package logger_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_OVF_W  = 8;

  // Per-bank lifecycle: EMPTY -> FILLING -> READY -> READING -> EMPTY
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;
  localparam logic [1:0] ST_READING = 2'd3;

endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array is not reset; only the read register clears on reset.
module dp_ram_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port: store the sample when enabled
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: one-cycle registered read, cleared while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong buffer controller: the writer fills one bank while the reader
// drains the other; samples arriving while both banks are held are dropped
// and counted.
module pingpong_buf_ctrl
  import logger_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OVF_W  = DEF_OVF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              wr_blocked,
  output logic              rd_avail,
  output logic              rd_bank,
  output logic [ADDR_W:0]   rd_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  output logic              ovf_flag,
  output logic [OVF_W-1:0]  ovf_cnt,
  input  logic              ovf_clr
);

  logic [1:0]        bank_st [2];
  logic [ADDR_W:0]   bank_len [2];
  logic              wb;
  logic              rs;
  logic [ADDR_W-1:0] wp;

  logic              wb_open;
  logic              do_write;
  logic              drop;
  logic [ADDR_W:0]   fill_len;
  logic              close;
  logic              release_bank;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + OVF_W'(1);
  endfunction

  // Write bank accepts data only while it is EMPTY or FILLING
  assign wb_open  = (bank_st[wb] == ST_EMPTY) || (bank_st[wb] == ST_FILLING);
  assign do_write = wr_valid && wb_open;
  assign drop     = wr_valid && !wb_open;
  // Length if the bank closed this cycle; a write at the last offset
  // naturally yields the full bank depth
  assign fill_len = {1'b0, wp} + (ADDR_W+1)'(do_write);
  assign close    = (do_write && (&wp)) || (flush && (fill_len != '0));

  assign rd_avail     = (bank_st[rs] == ST_READY) || (bank_st[rs] == ST_READING);
  assign release_bank = rd_done && rd_avail;
  assign rd_bank      = rs;
  assign rd_len       = bank_len[rs];
  assign wr_blocked   = !wb_open;

  // Bank state, pointers and lengths; reader and writer never touch the
  // same bank in one cycle because the write bank is blocked whenever it
  // is the one being offered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0]  <= ST_EMPTY;
      bank_st[1]  <= ST_EMPTY;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      wb          <= 1'b0;
      rs          <= 1'b0;
      wp          <= '0;
    end else begin
      if (rd_avail && (bank_st[rs] == ST_READY)) bank_st[rs] <= ST_READING;
      if (release_bank) begin
        bank_st[rs] <= ST_EMPTY;
        rs          <= ~rs;
      end
      if (close) begin
        bank_st[wb]  <= ST_READY;
        bank_len[wb] <= fill_len;
        wb           <= ~wb;
        wp           <= '0;
      end else if (do_write) begin
        bank_st[wb] <= ST_FILLING;
        wp          <= wp + ADDR_W'(1);
      end
    end
  end

  // Overflow tracking; clear wins over a coincident drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
      ovf_cnt  <= '0;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
      ovf_cnt  <= '0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
      ovf_cnt  <= sat_inc(ovf_cnt);
    end
  end

  dp_ram_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_write),
    .waddr ({wb, wp}),
    .wdata (wr_data),
    .raddr ({rs, rd_addr}),
    .rdata (rd_data)
  );

endmodule
